// File: rtl/serial_bus_arbiter_if.sv
// Bus bundle between the two serial masters, the arbiter and the slave_2K instances.
// The master modport is the arbiter's view; the slave modport is the view of the surrounding masters and slaves.
interface serial_bus_arbiter_if;
    logic [1:0] M_REQ;
    logic [1:0] M_GNT;
    logic [1:0] M_ADSEL;
    logic [1:0] M_BUS_OUT;
    logic [1:0] M_RW;
    logic [1:0] M_BUS_IN;
    logic [1:0] M_ACK;
    logic [2:0] AD_SEL;
    logic       B_BUS_OUT;
    logic       B_RW;
    logic [2:0] S_BUS_IN;
    logic [2:0] S_ACK;
    logic [2:0] S_SBSY;
    logic       ERR;
    logic [1:0] ERR_CODE;

    modport master (
        input  M_REQ, M_ADSEL, M_BUS_OUT, M_RW, S_BUS_IN, S_ACK, S_SBSY,
        output M_GNT, M_BUS_IN, M_ACK, AD_SEL, B_BUS_OUT, B_RW, ERR, ERR_CODE
    );

    modport slave (
        output M_REQ, M_ADSEL, M_BUS_OUT, M_RW, S_BUS_IN, S_ACK, S_SBSY,
        input  M_GNT, M_BUS_IN, M_ACK, AD_SEL, B_BUS_OUT, B_RW, ERR, ERR_CODE
    );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter for two serial masters with a 2-bit slave-ID decode that routes
// the granted master to one of three 2K slaves and releases on done, abort or timeout.
//
// state   | meaning
// IDLE    | no owner; arbitrate among requesters
// SELECT  | two cycles shifting in the slave ID, LSB first
// ACTIVE  | master routed to the selected slave; watch busy / request / timeout
// RELEASE | one cycle; drop grant, update pointer, pulse ERR if pending
module serial_bus_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    serial_bus_arbiter_if.master bus
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SELECT, ACTIVE, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            g_q, g_d;
    logic            ptr_q, ptr_d;
    logic [1:0]      sid_q, sid_d;
    logic            cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            seen_busy_q, seen_busy_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;

    logic            sel_busy, sel_ack, sel_rdata;
    logic [2:0]      ad_sel;
    logic [1:0]      m_bus_in, m_ack;
    logic            b_bus_out, b_rw;

    always_comb begin
        sel_busy  = 1'b0;
        sel_ack   = 1'b0;
        sel_rdata = 1'b0;
        case (sid_q)
            2'd0: begin
                sel_busy  = bus.S_SBSY[0];
                sel_ack   = bus.S_ACK[0];
                sel_rdata = bus.S_BUS_IN[0];
            end
            2'd1: begin
                sel_busy  = bus.S_SBSY[1];
                sel_ack   = bus.S_ACK[1];
                sel_rdata = bus.S_BUS_IN[1];
            end
            2'd2: begin
                sel_busy  = bus.S_SBSY[2];
                sel_ack   = bus.S_ACK[2];
                sel_rdata = bus.S_BUS_IN[2];
            end
            default: begin
                sel_busy  = 1'b0;
                sel_ack   = 1'b0;
                sel_rdata = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        g_d         = g_q;
        ptr_d       = ptr_q;
        sid_d       = sid_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        seen_busy_d = seen_busy_q;
        err_d       = 1'b0;
        err_code_d  = 2'd0;
        case (state_q)
            IDLE: begin
                if (|bus.M_REQ) begin
                    // On a tie the master that did not own the bus last wins
                    if (bus.M_REQ == 2'b11) g_d = ~ptr_q;
                    else                    g_d = bus.M_REQ[1];
                    gnt_d   = g_d ? 2'b10 : 2'b01;
                    cnt_d   = 1'b0;
                    sid_d   = 2'd0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                sid_d[cnt_q] = bus.M_BUS_OUT[g_q];
                cnt_d        = ~cnt_q;
                if (cnt_q) begin
                    if ({bus.M_BUS_OUT[g_q], sid_q[0]} == 2'b11) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                        state_d    = RELEASE;
                    end else begin
                        tmo_d       = '0;
                        seen_busy_d = 1'b0;
                        state_d     = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                // Once the slave has gone busy the transfer runs to completion regardless of M_REQ
                if (seen_busy_q) begin
                    if (!sel_busy) state_d = RELEASE;
                end else if (sel_busy) begin
                    seen_busy_d = 1'b1;
                end else if (!bus.M_REQ[g_q]) begin
                    state_d = RELEASE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = RELEASE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RELEASE: begin
                gnt_d   = 2'b00;
                ptr_d   = g_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            gnt_q       <= 2'b00;
            g_q         <= 1'b0;
            ptr_q       <= 1'b1;
            sid_q       <= 2'd0;
            cnt_q       <= 1'b0;
            tmo_q       <= '0;
            seen_busy_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            g_q         <= g_d;
            ptr_q       <= ptr_d;
            sid_q       <= sid_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            seen_busy_q <= seen_busy_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    always_comb begin
        ad_sel    = 3'b000;
        m_bus_in  = 2'b00;
        m_ack     = 2'b00;
        b_bus_out = 1'b0;
        b_rw      = 1'b0;
        if (state_q == ACTIVE) begin
            b_bus_out     = bus.M_BUS_OUT[g_q];
            b_rw          = bus.M_RW[g_q];
            m_bus_in[g_q] = sel_rdata;
            m_ack[g_q]    = sel_ack;
            case (sid_q)
                2'd0:    ad_sel = {2'b00, bus.M_ADSEL[g_q]};
                2'd1:    ad_sel = {1'b0, bus.M_ADSEL[g_q], 1'b0};
                2'd2:    ad_sel = {bus.M_ADSEL[g_q], 2'b00};
                default: ad_sel = 3'b000;
            endcase
        end
    end

    assign bus.M_GNT     = gnt_q;
    assign bus.AD_SEL    = ad_sel;
    assign bus.M_BUS_IN  = m_bus_in;
    assign bus.M_ACK     = m_ack;
    assign bus.B_BUS_OUT = b_bus_out;
    assign bus.B_RW      = b_rw;
    assign bus.ERR       = err_q;
    assign bus.ERR_CODE  = err_code_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter: single write, bad ID, timeout, abort,
// read held past request drop, reset mid-read, and tie round-robin.
module tb_serial_bus_arbiter;

    logic CLK;
    logic RSTN;
    int   n_cmp = 0;
    int   n_err = 0;

    serial_bus_arbiter_if bus ();

    serial_bus_arbiter #(.TIMEOUT(16)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.M_REQ     = 2'b00;
        bus.M_ADSEL   = 2'b00;
        bus.M_BUS_OUT = 2'b00;
        bus.M_RW      = 2'b00;
        bus.S_BUS_IN  = 3'b000;
        bus.S_ACK     = 3'b000;
        bus.S_SBSY    = 3'b000;
    endtask

    // Request the bus as master m alone and shift in sid; returns at the start of the cycle after bit1 is sampled
    task automatic start(input int m, input logic [1:0] sid);
        bus.M_REQ[m] = 1'b1;
        cyc();
        chk("grant", 32'(bus.M_GNT), 32'd1 << m);
        bus.M_BUS_OUT[m] = sid[0];
        #1;
        chk("adsel_in_select", 32'(bus.AD_SEL), 32'd0);
        cyc();
        bus.M_BUS_OUT[m] = sid[1];
        cyc();
        bus.M_BUS_OUT[m] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [23:0] wpat;
        logic [7:0]  rpat;
        logic [1:0]  tie_exp [4];
        wpat = 24'h5A3C96;
        rpat = 8'hB4;
        tie_exp[0] = 2'b01;
        tie_exp[1] = 2'b10;
        tie_exp[2] = 2'b01;
        tie_exp[3] = 2'b10;

        // reset values
        RSTN = 1'b0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_gnt", 32'(bus.M_GNT), 32'd0);
        chk("rst_err", 32'(bus.ERR), 32'd0);
        chk("rst_errcode", 32'(bus.ERR_CODE), 32'd0);
        chk("rst_adsel", 32'(bus.AD_SEL), 32'd0);
        chk("rst_bout", 32'(bus.B_BUS_OUT), 32'd0);
        chk("rst_ack", 32'(bus.M_ACK), 32'd0);
        RSTN = 1'b1;

        // single master write to slave 1
        start(0, 2'd1);
        bus.M_ADSEL[0] = 1'b1;
        bus.M_RW[0]    = 1'b1;
        for (int i = 0; i < 24; i++) begin
            bus.M_BUS_OUT[0] = wpat[23-i];
            if (i == 1) bus.S_SBSY[1] = 1'b1;
            #1;
            chk("wr_bout", 32'(bus.B_BUS_OUT), 32'(wpat[23-i]));
            chk("wr_adsel", 32'(bus.AD_SEL), 32'b010);
            chk("wr_rw", 32'(bus.B_RW), 32'd1);
            chk("wr_gnt", 32'(bus.M_GNT), 32'b01);
            cyc();
        end
        bus.M_ADSEL[0]   = 1'b0;
        bus.M_BUS_OUT[0] = 1'b0;
        bus.S_ACK[1]     = 1'b1;
        bus.S_BUS_IN[1]  = 1'b1;
        #1;
        chk("wr_ack", 32'(bus.M_ACK), 32'b01);
        chk("wr_busin", 32'(bus.M_BUS_IN), 32'b01);
        chk("wr_adsel_off", 32'(bus.AD_SEL), 32'd0);
        cyc();
        bus.S_ACK[1]    = 1'b0;
        bus.S_BUS_IN[1] = 1'b0;
        bus.S_SBSY[1]   = 1'b0;
        bus.M_REQ[0]    = 1'b0;
        cyc();
        chk("wr_rel_err", 32'(bus.ERR), 32'd0);
        chk("wr_rel_adsel", 32'(bus.AD_SEL), 32'd0);
        cyc();
        chk("wr_gnt_off", 32'(bus.M_GNT), 32'd0);
        chk("wr_err_off", 32'(bus.ERR), 32'd0);

        // bad slave ID from M1
        start(1, 2'd3);
        chk("bad_err", 32'(bus.ERR), 32'd1);
        chk("bad_code", 32'(bus.ERR_CODE), 32'd1);
        chk("bad_adsel", 32'(bus.AD_SEL), 32'd0);
        bus.M_REQ[1] = 1'b0;
        cyc();
        chk("bad_err_off", 32'(bus.ERR), 32'd0);
        chk("bad_code_off", 32'(bus.ERR_CODE), 32'd0);
        chk("bad_gnt_off", 32'(bus.M_GNT), 32'd0);

        // timeout: M0 to slave 2, never raises M_ADSEL
        start(0, 2'd2);
        for (int i = 1; i <= 16; i++) begin
            chk("tmo_adsel", 32'(bus.AD_SEL), 32'd0);
            cyc();
            if (i < 16) chk("tmo_err_early", 32'(bus.ERR), 32'd0);
        end
        chk("tmo_err", 32'(bus.ERR), 32'd1);
        chk("tmo_code", 32'(bus.ERR_CODE), 32'd2);
        bus.M_REQ[0] = 1'b0;
        bus.M_REQ[1] = 1'b1;
        cyc();
        chk("tmo_gnt_off", 32'(bus.M_GNT), 32'd0);
        chk("tmo_err_off", 32'(bus.ERR), 32'd0);
        cyc();
        chk("free_gnt_m1", 32'(bus.M_GNT), 32'b10);

        // abort: M1 drops request before any busy
        bus.M_REQ[1] = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("abort_err", 32'(bus.ERR), 32'd0);
        chk("abort_code", 32'(bus.ERR_CODE), 32'd0);
        cyc();
        chk("abort_gnt_off", 32'(bus.M_GNT), 32'd0);

        // read from slave 0; request dropped while busy, grant held until busy falls
        start(0, 2'd0);
        bus.M_ADSEL[0] = 1'b1;
        bus.M_RW[0]    = 1'b0;
        cyc();
        bus.S_SBSY[0] = 1'b1;
        cyc();
        bus.M_REQ[0]   = 1'b0;
        bus.M_ADSEL[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.S_BUS_IN[0] = rpat[7-i];
            #1;
            chk("rd_busin", 32'(bus.M_BUS_IN), 32'(rpat[7-i]));
            chk("rd_gnt_hold", 32'(bus.M_GNT), 32'b01);
            chk("rd_rw", 32'(bus.B_RW), 32'd0);
            cyc();
        end
        bus.S_SBSY[0]   = 1'b0;
        bus.S_BUS_IN[0] = 1'b0;
        cyc();
        chk("rd_rel_err", 32'(bus.ERR), 32'd0);
        cyc();
        chk("rd_gnt_off", 32'(bus.M_GNT), 32'd0);

        // reset in the middle of a read by M1 from slave 2
        start(1, 2'd2);
        bus.M_ADSEL[1] = 1'b1;
        #1;
        chk("mr_adsel", 32'(bus.AD_SEL), 32'b100);
        cyc();
        bus.S_SBSY[2]   = 1'b1;
        bus.S_BUS_IN[2] = 1'b1;
        #1;
        chk("mr_busin", 32'(bus.M_BUS_IN), 32'b10);
        #1;
        RSTN = 1'b0;
        #1;
        chk("mr_gnt", 32'(bus.M_GNT), 32'd0);
        chk("mr_adsel_off", 32'(bus.AD_SEL), 32'd0);
        chk("mr_busin_off", 32'(bus.M_BUS_IN), 32'd0);
        chk("mr_err", 32'(bus.ERR), 32'd0);
        clear_inputs();
        #3;
        RSTN = 1'b1;
        cyc();

        // tie round-robin straight out of reset
        bus.M_REQ = 2'b11;
        for (int t = 0; t < 4; t++) begin
            cyc();
            chk($sformatf("tie_gnt%0d", t), 32'(bus.M_GNT), 32'(tie_exp[t]));
            cyc();
            cyc();
            bus.S_SBSY[0] = 1'b1;
            cyc();
            bus.S_SBSY[0] = 1'b0;
            cyc();
            chk($sformatf("tie_err%0d", t), 32'(bus.ERR), 32'd0);
            cyc();
            chk($sformatf("tie_idle%0d", t), 32'(bus.M_GNT), 32'd0);
        end
        bus.M_REQ = 2'b00;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
